// File: rtl/ifu_pkg.sv
// Shared defaults and FSM encoding for the instruction fetch unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifu_pkg;

    localparam int ADDR_W_DEF   = 20;
    localparam int INST_W_DEF   = 20;
    localparam int RESET_PC_DEF = 0;
    localparam int DEPTH_DEF    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Synchronous FIFO of {pc, inst} pairs with push/pop/flush; head entry read from registers.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: caller must not push when full unless popping in the same cycle.
module ifu_prefetch_fifo #(
    parameter int ADDR_W = 20,
    parameter int INST_W = 20,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic [INST_W-1:0]        push_inst,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [ADDR_W-1:0]        head_pc,
    output logic [INST_W-1:0]        head_inst
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    assign head_valid = (count != '0);
    assign head_pc    = head_valid ? pc_mem[rd_ptr]   : '0;
    assign head_inst  = head_valid ? inst_mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC/FSM owner feeding {pc, inst} to decode through a prefetch FIFO; optional IFU_PERF_CNT_EN counters.
// Latency: start -> RUN next cycle -> first dec_valid one cycle later; redirect -> new target at dec two cycles later.
// Backpressure: fetch stalls (pc holds) while the FIFO is full and decode is not accepting.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                DEPTH    = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [INST_W-1:0] dec_inst,
    output logic [ADDR_W-1:0] dec_pc,
    output logic              busy
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    ifu_state_t         state;
    logic [ADDR_W-1:0]  pc;
    logic [CNT_W-1:0]   fifo_count;
    logic               dec_fire;
    logic               fetch_fire;

    assign imem_addr = pc;
    assign dec_fire  = dec_valid && dec_ready;
    assign fetch_fire = (state == RUN) && !halt_req && !redirect_valid &&
                        ((fifo_count < CNT_W'(DEPTH)) || dec_fire);

    // halt_req outranks start; redirect never touches the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else if (halt_req) begin
            if (state == RUN) begin
                state <= HALT;
                busy  <= 1'b0;
            end
        end else if (start && state != RUN) begin
            state <= RUN;
            busy  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (fetch_fire) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    ifu_prefetch_fifo #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (fetch_fire),
        .push_pc    (pc),
        .push_inst  (imem_inst),
        .pop        (dec_fire),
        .count      (fifo_count),
        .head_valid (dec_valid),
        .head_pc    (dec_pc),
        .head_inst  (dec_inst)
    );

`ifdef IFU_PERF_CNT_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fetch_fire && fetch_count != '1) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (dec_valid && !dec_ready && stall_count != '1) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Reader side of the instruction memory: owns the program counter, drives the memory address, captures the returned 20-bit instruction word, and hands {pc, inst} pairs to decode over a valid/ready handshake. A small prefetch FIFO decouples the memory read from decode backpressure. Supports start/halt control and branch redirect with flush. Sits between the instruction memory (combinational read) and the decode stage.

Parameters:
ADDR_W, 20, PC / memory address width
INST_W, 20, instruction word width
RESET_PC, 0, PC value loaded on reset
DEPTH, 2, prefetch FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  pulse: leave IDLE/HALT and begin fetching
halt_req  input  1  pulse: stop issuing new fetches
redirect_valid  input  1  branch/jump redirect strobe
redirect_pc  input  ADDR_W  redirect target
imem_addr  output  ADDR_W  address to instruction memory (= pc register)
imem_inst  input  INST_W  instruction word returned combinationally
dec_valid  output  1  FIFO head valid
dec_ready  input  1  decode accepts head
dec_inst  output  INST_W  head instruction
dec_pc  output  ADDR_W  head instruction address
busy  output  1  state == RUN

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, FIFO count=0, rd/wr pointers=0, state=IDLE; dec_valid=0, busy=0, dec_inst/dec_pc=0 while empty.
- imem_addr = pc at all times, combinational from the register; no other logic on that path.
- FSM states: IDLE, RUN, HALT.
  IDLE --start--> RUN; RUN --halt_req--> HALT; HALT --start--> RUN. start and halt_req in the same cycle: halt_req wins (RUN->HALT, IDLE/HALT unchanged).
- Fetch fires in a cycle when state==RUN, halt_req=0, redirect_valid=0, and (count<DEPTH or dec fire). On fire: push {pc, imem_inst}; pc <= pc+1 (word addressed, wraps modulo 2^ADDR_W).
- dec fire = dec_valid && dec_ready: pop head. Push and pop in the same cycle when full is legal; count unchanged.
- dec_valid = (count != 0); dec_inst/dec_pc are taken from the head entry, registered in the FIFO and stable while dec_valid && !dec_ready.
- Latency: start at cycle N -> RUN at N+1, first fetch at N+1 -> dec_valid=1 at N+2 with dec_pc=RESET_PC. Steady-state throughput is 1 instr/cycle with dec_ready held high.
- Redirect (highest priority, any state): pc <= redirect_pc; FIFO flushed (count=0, pointers reset); no push that cycle; a same-cycle dec fire is treated as consumed (head discarded either way); state unchanged. First redirected instruction reaches dec_valid two cycles after the redirect in RUN.
- HALT: no fetches; FIFO drains normally via dec_ready; pc holds next unfetched address; start resumes from that pc.
- Full FIFO with dec_ready=0: fetch stalls, pc holds, no overwrite.
- rst wins over all other inputs in the same cycle.

Optional Feature:
IFU_PERF_CNT_EN: adds outputs fetch_count[31:0] (increments on each fetch fire) and stall_count[31:0] (increments each cycle with dec_valid && !dec_ready). Both are cleared by rst and by no other input, and saturate at all-ones. Without the macro these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package ifu_pkg: ADDR_W/INST_W defaults, FSM state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2), RESET_PC default.
- One sub-module, ifu_prefetch_fifo: synchronous FIFO of {pc, inst}, DEPTH entries, with push/pop/flush/count. The top level holds the PC, FSM, fetch-enable logic and perf counters.

Test Plan:
- Reset then start, dec_ready=1, memory word k = k for k=0..7 -> dec_pc 0,1,2,..., dec_inst 20'h00000, 20'h00001, 20'h00002... one per cycle; first dec_valid two cycles after start.
- dec_ready=0 after start -> count saturates at DEPTH=2, imem_addr frozen at 2, dec_inst held at 20'h00000. Release dec_ready -> 0,1,2,3 delivered in order with no gap or duplicate.
- Redirect to 16 while the FIFO holds pc 3,4 -> both flushed; next outputs are dec_pc=16 with inst 20'h08180, then dec_pc=17 with inst 20'h02CB2.
- halt_req asserted with 2 entries queued -> both drain, then dec_valid=0 and busy=0. start -> resumes at the held pc with no skipped address.
- start and halt_req in the same cycle from RUN -> HALT. rst asserted mid-RUN with the FIFO full -> next cycle dec_valid=0, imem_addr=RESET_PC, state=IDLE.
- With IFU_PERF_CNT_EN, run 6 fetches with 3 backpressure cycles -> fetch_count=6, stall_count=3; both return to 0 after rst.
